// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states,
// default memory depth and the request fault check.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } state_e;

    localparam int unsigned ADDR_WORDS_DEFAULT = 256;

    // Misaligned, illegal size, or word index beyond the memory depth.
    function automatic logic is_fault(input logic [31:0] addr,
                                      input logic [1:0]  size,
                                      input int unsigned words);
        logic f;
        case (size_e'(size))
            SIZE_BYTE: f = 1'b0;
            SIZE_HALF: f = addr[0];
            SIZE_WORD: f = |addr[1:0];
            default:   f = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= words)
            f = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channel from the MEM stage and the word-organised memory port.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
                    input  req_ready, resp_valid, resp_rdata, resp_fault);
    modport slave  (input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
                    output req_ready, resp_valid, resp_rdata, resp_fault);
endinterface

interface lsu_mem_if;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data_out;

    modport master (output mem_address, mem_data_in, mem_read, mem_write,
                    input  mem_data_out);
    modport slave  (input  mem_address, mem_data_in, mem_read, mem_write,
                    output mem_data_out);
endinterface

// File: rtl/load_store_unit_align.sv
// Lane logic: extracts/extends sub-word loads and merges sub-word stores
// into the old word (little-endian).
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b     = old_word[{addr_lo, 3'b000} +: 8];
        lane_h     = addr_lo[1] ? old_word[31:16] : old_word[15:0];
        load_data  = old_word;
        store_word = store_data;
        case (size_e'(size))
            SIZE_BYTE: begin
                load_data  = {{24{~is_unsigned & lane_b[7]}}, lane_b};
                store_word = old_word;
                store_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
            end
            SIZE_HALF: begin
                load_data  = {{16{~is_unsigned & lane_h[15]}}, lane_h};
                store_word = addr_lo[1] ? {store_data[15:0], old_word[15:0]}
                                        : {old_word[31:16], store_data[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end: one request at a time, RMW for
// sub-word stores, fault reporting without memory access. All outputs registered.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_WORDS = ADDR_WORDS_DEFAULT
)(
    input  logic      clk,
    input  logic      rst_n,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);
    state_e      state, state_n;
    logic        r_write, r_unsigned;
    logic [1:0]  r_size, r_addr_lo;
    logic [31:0] r_wdata;

    logic        req_ready_n, resp_valid_n, resp_fault_n, mem_read_n, mem_write_n;
    logic [31:0] resp_rdata_n, mem_address_n, mem_data_in_n;
    logic [31:0] load_data, store_word;
    logic        accept;

    assign accept = (state == ST_IDLE) && req.req_valid;

    lsu_align u_align (
        .addr_lo     (r_addr_lo),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .old_word    (mem.mem_data_out),
        .store_data  (r_wdata),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    always_comb begin
        state_n       = state;
        resp_valid_n  = 1'b0;
        resp_fault_n  = 1'b0;
        resp_rdata_n  = '0;
        mem_read_n    = 1'b0;
        mem_write_n   = 1'b0;
        mem_address_n = mem.mem_address;
        mem_data_in_n = mem.mem_data_in;
        case (state)
            ST_IDLE: if (accept) begin
                if (is_fault(req.req_addr, req.req_size, ADDR_WORDS)) begin
                    state_n      = ST_RESP;
                    resp_valid_n = 1'b1;
                    resp_fault_n = 1'b1;
                end else begin
                    mem_address_n = {2'b00, req.req_addr[31:2]};
                    if (req.req_write && size_e'(req.req_size) == SIZE_WORD) begin
                        state_n       = ST_WR;
                        mem_write_n   = 1'b1;
                        mem_data_in_n = req.req_wdata;
                    end else begin
                        state_n    = ST_RD;
                        mem_read_n = 1'b1;
                    end
                end
            end
            // Read data is consumed here: extended for loads, merged for sub-word stores.
            ST_RD: if (r_write) begin
                state_n       = ST_WR;
                mem_write_n   = 1'b1;
                mem_data_in_n = store_word;
            end else begin
                state_n      = ST_RESP;
                resp_valid_n = 1'b1;
                resp_rdata_n = load_data;
            end
            ST_WR: begin
                state_n      = ST_RESP;
                resp_valid_n = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
        req_ready_n = (state_n == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            req.req_ready   <= 1'b1;
            req.resp_valid  <= 1'b0;
            req.resp_rdata  <= '0;
            req.resp_fault  <= 1'b0;
            mem.mem_read    <= 1'b0;
            mem.mem_write   <= 1'b0;
            mem.mem_address <= '0;
            mem.mem_data_in <= '0;
            r_write         <= 1'b0;
            r_unsigned      <= 1'b0;
            r_size          <= '0;
            r_addr_lo       <= '0;
            r_wdata         <= '0;
        end else begin
            state           <= state_n;
            req.req_ready   <= req_ready_n;
            req.resp_valid  <= resp_valid_n;
            req.resp_rdata  <= resp_rdata_n;
            req.resp_fault  <= resp_fault_n;
            mem.mem_read    <= mem_read_n;
            mem.mem_write   <= mem_write_n;
            mem.mem_address <= mem_address_n;
            mem.mem_data_in <= mem_data_in_n;
            if (accept) begin
                r_write    <= req.req_write;
                r_unsigned <= req.req_unsigned;
                r_size     <= req.req_size;
                r_addr_lo  <= req.req_addr[1:0];
                r_wdata    <= req.req_wdata;
            end
        end
    end
endmodule
